// File: rtl/tt_wrap_pkg.sv
// Shared types and helpers for the sequenced TT project wrapper.
// The status width constants are meaningful when TT_WRAP_STATUS_EN is defined.
package tt_wrap_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } wrap_state_t;

    localparam int RUN_CNT_W = 16;
    localparam int STATUS_W  = 2 + RUN_CNT_W;

    // Counter must hold the larger of the two reload values.
    function automatic int cnt_width(input int hold_cyc, input int drain_cyc);
        int m;
        m = (hold_cyc > drain_cyc) ? hold_cyc : drain_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tt_proj_wrapper_seq_if.sv
// Project-side TT port set; master is the wrapper, slave is the attached tt_um_* design.
interface tt_proj_wrapper_seq_if #(
    parameter int N_UI  = 8,
    parameter int N_UO  = 8,
    parameter int N_UIO = 8
);
    logic             p_rst_n;
    logic             p_ena;
    logic [N_UI-1:0]  p_ui_in;
    logic [N_UIO-1:0] p_uio_in;
    logic [N_UO-1:0]  p_uo_out;
    logic [N_UIO-1:0] p_uio_out;
    logic [N_UIO-1:0] p_uio_oe;

    modport master (
        output p_rst_n, p_ena, p_ui_in, p_uio_in,
        input  p_uo_out, p_uio_out, p_uio_oe
    );

    modport slave (
        input  p_rst_n, p_ena, p_ui_in, p_uio_in,
        output p_uo_out, p_uio_out, p_uio_oe
    );
endinterface

// File: rtl/tt_wrap_seq.sv
// Enable synchroniser plus OFF/HOLD/RUN/DRAIN sequencer for the project wrapper.
// With TT_WRAP_STATUS_EN defined, also keeps a saturating count of RUN cycles.
module tt_wrap_seq
    import tt_wrap_pkg::*;
#(
    parameter int RST_HOLD  = 4,
    parameter int DRAIN_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    output wrap_state_t          state,
    output logic                 run_active,
    output logic                 hold_active
`ifdef TT_WRAP_STATUS_EN
    ,
    output logic [RUN_CNT_W-1:0] run_cnt
`endif
);

    localparam int CW = cnt_width(RST_HOLD, DRAIN_CYC);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic          ena_meta;
    logic          ena_s;
    wrap_state_t   state_q;
    wrap_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_meta <= 1'b0;
            ena_s    <= 1'b0;
        end else begin
            ena_meta <= ena;
            ena_s    <= ena_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // DRAIN deliberately ignores ena_s so a re-enable cannot cut the drain short.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (ena_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!ena_s) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!ena_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef TT_WRAP_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if ((state_q != ST_HOLD) && (state_d == ST_HOLD)) begin
            run_cnt <= '0;
        end else if ((state_q == ST_RUN) && (run_cnt != '1)) begin
            run_cnt <= run_cnt + RUN_CNT_W'(1);
        end
    end
`endif

    assign state       = state_q;
    assign run_active  = (state_q == ST_RUN);
    assign hold_active = (state_q == ST_HOLD);

endmodule

// File: rtl/tt_proj_wrapper_seq.sv
// Sequenced TT project wrapper: packs iw/ow, isolates the project outside RUN.
// Optional status port enabled by defining TT_WRAP_STATUS_EN.
module tt_proj_wrapper_seq
    import tt_wrap_pkg::*;
#(
    parameter int N_UI      = 8,
    parameter int N_UO      = 8,
    parameter int N_UIO     = 8,
    parameter int RST_HOLD  = 4,
    parameter int DRAIN_CYC = 2,
    parameter int OUT_REG   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [N_UIO+N_UI:0]       iw,
    output logic [2*N_UIO+N_UO-1:0]   ow,
    output logic                      p_clk,
    tt_proj_wrapper_seq_if.master     prj
`ifdef TT_WRAP_STATUS_EN
    ,
    output logic [STATUS_W-1:0]       status
`endif
);

    localparam int OW_W = 2 * N_UIO + N_UO;

    wrap_state_t      state;
    logic             run_active;
    logic             hold_active;
    logic             rst_n_req;
    logic [N_UI-1:0]  ui_in;
    logic [N_UIO-1:0] uio_in;
    logic [OW_W-1:0]  ow_raw;
    logic [OW_W-1:0]  ow_masked;

`ifdef TT_WRAP_STATUS_EN
    logic [RUN_CNT_W-1:0] run_cnt;
`endif

    tt_wrap_seq #(
        .RST_HOLD  (RST_HOLD),
        .DRAIN_CYC (DRAIN_CYC)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .state       (state),
        .run_active  (run_active),
        .hold_active (hold_active)
`ifdef TT_WRAP_STATUS_EN
        ,
        .run_cnt     (run_cnt)
`endif
    );

    assign rst_n_req = iw[0];
    assign ui_in     = iw[N_UI:1];
    assign uio_in    = iw[N_UIO+N_UI:N_UI+1];

    assign p_clk        = clk;
    assign prj.p_ena    = (state != ST_OFF);
    assign prj.p_rst_n  = (state != ST_OFF) && !hold_active && rst_n_req;
    assign prj.p_ui_in  = run_active ? ui_in  : '0;
    assign prj.p_uio_in = run_active ? uio_in : '0;

    // Masking uio_oe outside RUN is what keeps the pads from contending.
    assign ow_raw    = {prj.p_uio_oe, prj.p_uio_out, prj.p_uo_out};
    assign ow_masked = run_active ? ow_raw : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [OW_W-1:0] ow_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ow_q <= '0;
                end else begin
                    ow_q <= ow_masked;
                end
            end

            assign ow = ow_q;
        end else begin : g_out_comb
            assign ow = ow_masked;
        end
    endgenerate

`ifdef TT_WRAP_STATUS_EN
    assign status = {state, run_cnt};
`endif

endmodule

// File: tb/tb_tt_proj_wrapper_seq.sv
// Self-checking bench for tt_proj_wrapper_seq (registered and combinational ow builds).
// Status checks are compiled in when TT_WRAP_STATUS_EN is defined.
module tb_tt_proj_wrapper_seq;

    localparam int RST_HOLD  = 4;
    localparam int DRAIN_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [16:0] iw;
    logic [7:0]  uo_drv;
    logic [7:0]  uio_drv;
    logic [7:0]  oe_drv;
    logic [23:0] ow_r;
    logic [23:0] ow_c;
    logic        p_clk_r;
    logic        p_clk_c;
`ifdef TT_WRAP_STATUS_EN
    logic [17:0] status_r;
    logic [17:0] status_c;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_proj_wrapper_seq_if #(.N_UI(8), .N_UO(8), .N_UIO(8)) prj_r ();
    tt_proj_wrapper_seq_if #(.N_UI(8), .N_UO(8), .N_UIO(8)) prj_c ();

    assign prj_r.p_uo_out  = uo_drv;
    assign prj_r.p_uio_out = uio_drv;
    assign prj_r.p_uio_oe  = oe_drv;
    assign prj_c.p_uo_out  = uo_drv;
    assign prj_c.p_uio_out = uio_drv;
    assign prj_c.p_uio_oe  = oe_drv;

    tt_proj_wrapper_seq #(
        .N_UI(8), .N_UO(8), .N_UIO(8),
        .RST_HOLD(RST_HOLD), .DRAIN_CYC(DRAIN_CYC), .OUT_REG(1)
    ) dut_r (
        .clk(clk), .rst(rst), .ena(ena), .iw(iw), .ow(ow_r), .p_clk(p_clk_r), .prj(prj_r)
`ifdef TT_WRAP_STATUS_EN
        , .status(status_r)
`endif
    );

    tt_proj_wrapper_seq #(
        .N_UI(8), .N_UO(8), .N_UIO(8),
        .RST_HOLD(RST_HOLD), .DRAIN_CYC(DRAIN_CYC), .OUT_REG(0)
    ) dut_c (
        .clk(clk), .rst(rst), .ena(ena), .iw(iw), .ow(ow_c), .p_clk(p_clk_c), .prj(prj_c)
`ifdef TT_WRAP_STATUS_EN
        , .status(status_c)
`endif
    );

    // Reference model: phase plus cycles-remaining, ena seen through a 2-deep delay line.
    typedef enum int {M_OFF, M_HOLD, M_RUN, M_DRAIN} mphase_t;

    mphase_t     m_ph;
    int          m_left;
    bit          m_sy1;
    bit          m_sy2;
    logic [23:0] m_ow_reg;
    int          m_run;

    logic        exp_p_ena;
    logic        exp_p_rst_n;
    logic [7:0]  exp_ui;
    logic [7:0]  exp_uio;
    logic [23:0] exp_ow_r;
    logic [23:0] exp_ow_c;
    logic [17:0] exp_status;

    task automatic model_reset();
        m_ph     = M_OFF;
        m_left   = 0;
        m_sy1    = 1'b0;
        m_sy2    = 1'b0;
        m_ow_reg = '0;
        m_run    = 0;
    endtask

    task automatic model_edge();
        bit seen;
        if (rst) begin
            model_reset();
            return;
        end
        seen = m_sy2;
        m_ow_reg = (m_ph == M_RUN) ? {oe_drv, uio_drv, uo_drv} : 24'h0;
        if (m_ph == M_RUN && m_run < 65535) m_run++;
        case (m_ph)
            M_OFF: if (seen) begin
                m_ph   = M_HOLD;
                m_left = RST_HOLD;
                m_run  = 0;
            end
            M_HOLD: if (!seen) begin
                m_ph = M_OFF;
            end else begin
                m_left--;
                if (m_left == 0) m_ph = M_RUN;
            end
            M_RUN: if (!seen) begin
                m_ph   = M_DRAIN;
                m_left = DRAIN_CYC;
            end
            M_DRAIN: begin
                m_left--;
                if (m_left == 0) m_ph = M_OFF;
            end
            default: m_ph = M_OFF;
        endcase
        m_sy2 = m_sy1;
        m_sy1 = ena;
    endtask

    task automatic model_eval();
        logic [1:0] code;
        bit running;
        running     = (m_ph == M_RUN);
        exp_p_ena   = (m_ph != M_OFF);
        exp_p_rst_n = (m_ph == M_RUN || m_ph == M_DRAIN) ? iw[0] : 1'b0;
        exp_ui      = running ? iw[8:1]  : 8'h00;
        exp_uio     = running ? iw[16:9] : 8'h00;
        exp_ow_r    = m_ow_reg;
        exp_ow_c    = running ? {oe_drv, uio_drv, uo_drv} : 24'h0;
        case (m_ph)
            M_HOLD:  code = 2'd1;
            M_RUN:   code = 2'd2;
            M_DRAIN: code = 2'd3;
            default: code = 2'd0;
        endcase
        exp_status = {code, 16'(m_run)};
    endtask

    // Drive inputs just after a falling edge, clock once, return at the next falling edge.
    task automatic step(input logic r, input logic e, input logic [16:0] w,
                        input logic [7:0] uo, input logic [7:0] uio, input logic [7:0] oe);
        rst     = r;
        ena     = e;
        iw      = w;
        uo_drv  = uo;
        uio_drv = uio;
        oe_drv  = oe;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_eval();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, '1, 8'hFF, 8'hFF, 8'hFF);
            checks += 6;
            if (ow_r !== 24'h0) begin errors++; $display("[TB] FAIL reset_ow_reg: got %h expected 000000", ow_r); end
            if (ow_c !== 24'h0) begin errors++; $display("[TB] FAIL reset_ow_comb: got %h expected 000000", ow_c); end
            if (prj_r.p_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_p_rst_n: got %b expected 0", prj_r.p_rst_n); end
            if (prj_r.p_ena !== 1'b0) begin errors++; $display("[TB] FAIL reset_p_ena: got %b expected 0", prj_r.p_ena); end
            if (prj_r.p_ui_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_p_ui_in: got %h expected 00", prj_r.p_ui_in); end
            if (prj_c.p_uio_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_p_uio_in: got %h expected 00", prj_c.p_uio_in); end
        end
        checks++;
        if (p_clk_r !== 1'b0) begin errors++; $display("[TB] FAIL p_clk: got %b expected 0", p_clk_r); end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 8'h00, 8'h00, 8'h00);
    endtask

    // ena rises before edge 0: HOLD after edge 2, RUN after edge 6, registered ow after edge 7.
    task automatic test_enable_sequence();
        for (int k = 0; k <= 8; k++) begin
            step(1'b0, 1'b1, {8'h00, 8'h3C, 1'b1}, 8'hA5, 8'h00, 8'h00);
            checks += 5;
            if (prj_r.p_ena !== (k >= 2)) begin errors++; $display("[TB] FAIL enable_p_ena[%0d]: got %b expected %b", k, prj_r.p_ena, (k >= 2)); end
            if (prj_r.p_rst_n !== (k >= 6)) begin errors++; $display("[TB] FAIL enable_p_rst_n[%0d]: got %b expected %b", k, prj_r.p_rst_n, (k >= 6)); end
            if (ow_r !== ((k >= 7) ? 24'h0000A5 : 24'h0)) begin errors++; $display("[TB] FAIL enable_ow_reg[%0d]: got %h expected %h", k, ow_r, ((k >= 7) ? 24'h0000A5 : 24'h0)); end
            if (ow_c !== ((k >= 6) ? 24'h0000A5 : 24'h0)) begin errors++; $display("[TB] FAIL enable_ow_comb[%0d]: got %h expected %h", k, ow_c, ((k >= 6) ? 24'h0000A5 : 24'h0)); end
            if (prj_r.p_ui_in !== ((k >= 6) ? 8'h3C : 8'h00)) begin errors++; $display("[TB] FAIL enable_p_ui_in[%0d]: got %h expected %h", k, prj_r.p_ui_in, ((k >= 6) ? 8'h3C : 8'h00)); end
        end
    endtask

    // ena drops before edge 0: DRAIN after edge 2, OFF after edge 4.
    task automatic test_disable_sequence();
        step(1'b0, 1'b1, {8'h00, 8'h3C, 1'b1}, 8'h5A, 8'hC3, 8'hFF);
        checks++;
        if (ow_r !== 24'hFFC35A) begin errors++; $display("[TB] FAIL disable_pre_ow: got %h expected FFC35A", ow_r); end
        for (int j = 0; j <= 5; j++) begin
            step(1'b0, 1'b0, {8'h00, 8'h3C, 1'b1}, 8'h5A, 8'hC3, 8'hFF);
            checks += 5;
            if (prj_r.p_ena !== (j < 4)) begin errors++; $display("[TB] FAIL disable_p_ena[%0d]: got %b expected %b", j, prj_r.p_ena, (j < 4)); end
            if (prj_r.p_rst_n !== (j < 4)) begin errors++; $display("[TB] FAIL disable_p_rst_n[%0d]: got %b expected %b", j, prj_r.p_rst_n, (j < 4)); end
            if (ow_r !== ((j <= 2) ? 24'hFFC35A : 24'h0)) begin errors++; $display("[TB] FAIL disable_ow_reg[%0d]: got %h expected %h", j, ow_r, ((j <= 2) ? 24'hFFC35A : 24'h0)); end
            if (ow_c !== ((j < 2) ? 24'hFFC35A : 24'h0)) begin errors++; $display("[TB] FAIL disable_ow_comb[%0d]: got %h expected %h", j, ow_c, ((j < 2) ? 24'hFFC35A : 24'h0)); end
            if (prj_c.p_ui_in !== ((j < 2) ? 8'h3C : 8'h00)) begin errors++; $display("[TB] FAIL disable_p_ui_in[%0d]: got %h expected %h", j, prj_c.p_ui_in, ((j < 2) ? 8'h3C : 8'h00)); end
        end
    endtask

    task automatic test_glitch();
        for (int j = 0; j < 10; j++) begin
            step(1'b0, (j == 0), {8'h55, 8'h3C, 1'b1}, 8'hFF, 8'hFF, 8'hFF);
            checks += 4;
            if (prj_r.p_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL glitch_p_rst_n[%0d]: got %b expected 0", j, prj_r.p_rst_n); end
            if (ow_r !== 24'h0) begin errors++; $display("[TB] FAIL glitch_ow_reg[%0d]: got %h expected 000000", j, ow_r); end
            if (ow_c !== 24'h0) begin errors++; $display("[TB] FAIL glitch_ow_comb[%0d]: got %h expected 000000", j, ow_c); end
            if (prj_r.p_ena !== exp_p_ena) begin errors++; $display("[TB] FAIL glitch_p_ena[%0d]: got %b expected %b", j, prj_r.p_ena, exp_p_ena); end
        end
    endtask

    task automatic test_reenable_drain();
        int n_off;
        int n_hold;
        int n_drain;
        n_off = 0;
        n_hold = 0;
        n_drain = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, {8'h00, 8'h3C, 1'b1}, 8'h11, 8'h22, 8'h33);
        checks++;
        if (prj_r.p_ui_in !== 8'h3C) begin errors++; $display("[TB] FAIL reenable_in_run: got %h expected 3C", prj_r.p_ui_in); end
        for (int j = 0; j < 14; j++) begin
            step(1'b0, (j >= 3), {8'h00, 8'h3C, 1'b1}, 8'h11, 8'h22, 8'h33);
            if (!prj_r.p_ena) n_off++;
            else if (!prj_r.p_rst_n) n_hold++;
            else if (prj_r.p_ui_in == 8'h00) n_drain++;
            checks++;
            if (prj_r.p_ena !== exp_p_ena) begin errors++; $display("[TB] FAIL reenable_p_ena[%0d]: got %b expected %b", j, prj_r.p_ena, exp_p_ena); end
        end
        checks += 4;
        if (n_drain != DRAIN_CYC) begin errors++; $display("[TB] FAIL reenable_drain_len: got %0d expected %0d", n_drain, DRAIN_CYC); end
        if (n_off != 1) begin errors++; $display("[TB] FAIL reenable_off_len: got %0d expected 1", n_off); end
        if (n_hold != RST_HOLD) begin errors++; $display("[TB] FAIL reenable_hold_len: got %0d expected %0d", n_hold, RST_HOLD); end
        if (ow_r !== 24'h332211) begin errors++; $display("[TB] FAIL reenable_final_ow: got %h expected 332211", ow_r); end
    endtask

    task automatic test_random();
        logic e;
        logic r;
        e = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) e = ~e;
            r = ($urandom_range(0, 149) == 0);
            step(r, e, 17'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            checks += 6;
            if (prj_r.p_ena !== exp_p_ena) begin errors++; $display("[TB] FAIL rand_p_ena[%0d]: got %b expected %b", i, prj_r.p_ena, exp_p_ena); end
            if (prj_r.p_rst_n !== exp_p_rst_n) begin errors++; $display("[TB] FAIL rand_p_rst_n[%0d]: got %b expected %b", i, prj_r.p_rst_n, exp_p_rst_n); end
            if (prj_r.p_ui_in !== exp_ui) begin errors++; $display("[TB] FAIL rand_p_ui_in[%0d]: got %h expected %h", i, prj_r.p_ui_in, exp_ui); end
            if (prj_c.p_uio_in !== exp_uio) begin errors++; $display("[TB] FAIL rand_p_uio_in[%0d]: got %h expected %h", i, prj_c.p_uio_in, exp_uio); end
            if (ow_r !== exp_ow_r) begin errors++; $display("[TB] FAIL rand_ow_reg[%0d]: got %h expected %h", i, ow_r, exp_ow_r); end
            if (ow_c !== exp_ow_c) begin errors++; $display("[TB] FAIL rand_ow_comb[%0d]: got %h expected %h", i, ow_c, exp_ow_c); end
`ifdef TT_WRAP_STATUS_EN
            checks++;
            if (status_r !== exp_status) begin errors++; $display("[TB] FAIL rand_status[%0d]: got %h expected %h", i, status_r, exp_status); end
`endif
        end
    endtask

`ifdef TT_WRAP_STATUS_EN
    task automatic test_status();
        int n;
        step(1'b1, 1'b0, '0, 8'h00, 8'h00, 8'h00);
        n = 0;
        do begin
            step(1'b0, 1'b1, {8'h00, 8'h00, 1'b1}, 8'h00, 8'h00, 8'h00);
            n++;
        end while (prj_r.p_rst_n !== 1'b1 && n < 20);
        checks++;
        if (prj_r.p_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL status_run_timeout: got p_rst_n %b expected 1", prj_r.p_rst_n); end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, {8'h00, 8'h00, 1'b1}, 8'h00, 8'h00, 8'h00);
        checks++;
        if (status_r !== {2'd2, 16'd10}) begin errors++; $display("[TB] FAIL status_run10: got %h expected %h", status_r, {2'd2, 16'd10}); end
        for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, {8'h00, 8'h00, 1'b1}, 8'h00, 8'h00, 8'h00);
        checks += 2;
        if (status_r !== {2'd2, 16'hFFFF}) begin errors++; $display("[TB] FAIL status_saturate: got %h expected %h", status_r, {2'd2, 16'hFFFF}); end
        if (status_c !== exp_status) begin errors++; $display("[TB] FAIL status_model: got %h expected %h", status_c, exp_status); end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, {8'h00, 8'h00, 1'b1}, 8'h00, 8'h00, 8'h00);
        n = 0;
        do begin
            step(1'b0, 1'b1, {8'h00, 8'h00, 1'b1}, 8'h00, 8'h00, 8'h00);
            n++;
        end while (!(prj_r.p_ena === 1'b1 && prj_r.p_rst_n === 1'b0) && n < 20);
        checks++;
        if (status_r !== {2'd1, 16'd0}) begin errors++; $display("[TB] FAIL status_hold_clear: got %h expected %h", status_r, {2'd1, 16'd0}); end
    endtask
`endif

    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        ena     = 1'b0;
        iw      = '0;
        uo_drv  = '0;
        uio_drv = '0;
        oe_drv  = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_enable_sequence();
        test_disable_sequence();
        test_glitch();
        test_reenable_drain();
        test_random();
`ifdef TT_WRAP_STATUS_EN
        test_status();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
